// File: rtl/ceespu_regfile_mp.sv
// ceespu_regfile_mp: parametrised multi-read-port register file with hardware clear sequencer
module ceespu_regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic [NREAD*ADDR_W-1:0] I_sel,
  output logic [NREAD*DATA_W-1:0] O_data,
  input  logic                    I_we,
  input  logic [ADDR_W-1:0]       I_selD,
  input  logic [DATA_W-1:0]       I_dataD,
  input  logic                    I_clear,
  output logic                    O_busy,
  output logic                    O_wdrop
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  logic [0:0] state;
  logic [ADDR_W:0] clr_idx;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic clearing, wr_ok;
  assign clearing = state == CLEAR;
  assign O_busy = clearing;
  assign wr_ok = !clearing && I_we && !I_clear && !(ZERO_R0 != 0 && I_selD == '0);
  always_ff @(posedge I_clk or posedge I_rst)
    if (I_rst) begin
      state <= CLEAR;
      clr_idx <= '0;
      O_wdrop <= 1'b0;
    end else begin
      O_wdrop <= I_we && (clearing || I_clear);
      clr_idx <= (I_clear || !clearing) ? '0 : clr_idx + ONE;
      state <= I_clear ? CLEAR : (clearing && clr_idx == LAST) ? READY : state;
    end
  // The sweep and the write port share one physical write port; reset blocks both.
  always_ff @(posedge I_clk)
    if (!I_rst && (clearing || wr_ok))
      mem[clearing ? clr_idx[ADDR_W-1:0] : I_selD] <= clearing ? '0 : I_dataD;
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] s;
    assign s = I_sel[k*ADDR_W +: ADDR_W];
    assign O_data[k*DATA_W +: DATA_W] = (clearing || (ZERO_R0 != 0 && s == '0)) ? '0 :
                                        (BYPASS != 0 && wr_ok && s == I_selD) ? I_dataD : mem[s];
  end
endmodule

// File: tb/tb_ceespu_regfile_mp.sv
// tb_ceespu_regfile_mp: directed checks of three register file configurations
module tb_ceespu_regfile_mp;
  logic clk = 1'b0, rst = 1'b1;
  always #50 clk = ~clk;

  logic [9:0] a_sel = '0, b_sel = '0;
  logic [11:0] c_sel = '0;
  logic [63:0] a_data, b_data, c_data;
  logic a_we = 0, b_we = 0, c_we = 0, a_clear = 0, b_clear = 0, c_clear = 0;
  logic [4:0] a_seld = '0, b_seld = '0;
  logic [2:0] c_seld = '0;
  logic [31:0] a_datad = '0, b_datad = '0;
  logic [15:0] c_datad = '0;
  logic a_busy, b_busy, c_busy, a_wdrop, b_wdrop, c_wdrop;

  ceespu_regfile_mp dut_a (.I_clk(clk), .I_rst(rst), .I_sel(a_sel), .O_data(a_data), .I_we(a_we),
    .I_selD(a_seld), .I_dataD(a_datad), .I_clear(a_clear), .O_busy(a_busy), .O_wdrop(a_wdrop));
  ceespu_regfile_mp #(.BYPASS(0), .ZERO_R0(0)) dut_b (.I_clk(clk), .I_rst(rst), .I_sel(b_sel),
    .O_data(b_data), .I_we(b_we), .I_selD(b_seld), .I_dataD(b_datad), .I_clear(b_clear),
    .O_busy(b_busy), .O_wdrop(b_wdrop));
  ceespu_regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4)) dut_c (.I_clk(clk), .I_rst(rst),
    .I_sel(c_sel), .O_data(c_data), .I_we(c_we), .I_selD(c_seld), .I_dataD(c_datad),
    .I_clear(c_clear), .O_busy(c_busy), .O_wdrop(c_wdrop));

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One pass over a full sweep from its first busy window; optionally injects a write at drop_at.
  task automatic sweep(input int drop_at, input bit with_c);
    for (int i = 0; i < 33; i++) begin
      a_we = (i == drop_at);
      a_seld = 5'd3;
      a_datad = 32'h55;
      a_sel = {5'd1, 5'(i)};
      #10;
      chk("sweep_busy_a", 64'(a_busy), 64'(i < 32));
      chk("sweep_wdrop_a", 64'(a_wdrop), 64'(drop_at >= 0 && i == drop_at + 1));
      if (i < 32) chk("sweep_data_a", a_data, 64'h0);
      if (with_c) chk("sweep_busy_c", 64'(c_busy), 64'(i < 8));
      @(negedge clk);
    end
    a_we = 0;
  endtask

  typedef struct {
    logic we, clear;
    logic [4:0] seld, s0, s1;
    logic [31:0] d, e0, e1;
    logic busy, wdrop;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd6, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 5'd7, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 5'd8, 5'd8, 5'd7, 32'h1, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    #10;
    chk("rst_busy", 64'(a_busy), 64'h1);
    chk("rst_wdrop", 64'(a_wdrop), 64'h0);
    chk("rst_data", a_data, 64'h0);
    @(negedge clk);
    rst = 0;
    sweep(9, 1'b1);
    for (int i = 0; i < 32; i++) begin
      a_sel = {5'(31 - i), 5'(i)};
      #1;
      chk("post_sweep_zero", a_data, 64'h0);
    end
    @(negedge clk);
    foreach (tbl[i]) begin
      a_we = tbl[i].we;
      a_clear = tbl[i].clear;
      a_seld = tbl[i].seld;
      a_datad = tbl[i].d;
      a_sel = {tbl[i].s1, tbl[i].s0};
      #10;
      chk($sformatf("vec%0d_p0", i), 64'(a_data[31:0]), 64'(tbl[i].e0));
      chk($sformatf("vec%0d_p1", i), 64'(a_data[63:32]), 64'(tbl[i].e1));
      chk($sformatf("vec%0d_busy", i), 64'(a_busy), 64'(tbl[i].busy));
      chk($sformatf("vec%0d_wdrop", i), 64'(a_wdrop), 64'(tbl[i].wdrop));
      @(negedge clk);
    end
    for (int i = 2; i < 33; i++) begin
      #10;
      chk("clear_busy", 64'(a_busy), 64'(i < 32));
      @(negedge clk);
    end
    a_sel = {5'd8, 5'd7};
    #10;
    chk("clear_r7_r8", a_data, 64'h0);
    b_we = 1; b_seld = 5'd5; b_datad = 32'hDEADBEEF; b_sel = {5'd5, 5'd5};
    #10;
    chk("b_no_bypass", b_data, 64'h0);
    @(negedge clk);
    b_seld = 5'd0; b_datad = 32'h1234; b_sel = {5'd5, 5'd0};
    #10;
    chk("b_r5_next", b_data, {32'hDEADBEEF, 32'h0});
    @(negedge clk);
    b_we = 0; b_sel = {5'd0, 5'd0};
    #10;
    chk("b_r0_written", b_data, {32'h1234, 32'h1234});
    chk("b_wdrop", 64'(b_wdrop), 64'h0);
    @(negedge clk);
    c_we = 1; c_seld = 3'd1; c_datad = 16'h1111;
    @(negedge clk);
    c_seld = 3'd2; c_datad = 16'h2222;
    @(negedge clk);
    c_seld = 3'd3; c_datad = 16'h3333;
    @(negedge clk);
    c_seld = 3'd6; c_datad = 16'h6666; c_sel = {3'd6, 3'd3, 3'd2, 3'd1};
    #10;
    chk("c_four_ports", c_data, 64'h6666_3333_2222_1111);
    @(negedge clk);
    c_we = 0; c_sel = {3'd0, 3'd2, 3'd2, 3'd6};
    #10;
    chk("c_shared_sel", c_data, 64'h0000_2222_2222_6666);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #10;
    rst = 1;
    #5;
    chk("midrst_busy", 64'(a_busy), 64'h1);
    chk("midrst_data", a_data, 64'h0);
    @(negedge clk);
    rst = 0;
    sweep(-1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
